muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle multiply/divide controller for the pipelined core's EX stage. Accepts MIPS mult/multu/div/divu, runs a 32-iteration shift-add / restoring-divide sequence on its own datapath, and writes the 64-bit result to the internal HI/LO registers. It stalls the front of the pipeline only when a later mult/div/mfhi/mflo reaches EX while a sequence is in flight; independent instructions continue to flow.

## Interface
Parameters:
- ITER, 32, iteration count (operand width); fixed at 32 for this core.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MDStart  in  1  EX stage holds a mult/div instruction this cycle.
- MDFunct  in  6  funct field: 011000 mult, 011001 multu, 011010 div, 011011 divu.
- MfRead  in  1  EX stage holds mfhi (010000) or mflo (010010).
- SrcAE  in  32  rs operand (multiplicand / dividend).
- SrcBE  in  32  rt operand (multiplier / divisor).
- MDStall  out  1  freeze F/D/E pipeline registers and bubble M.
- MDBusy  out  1  sequence in flight.
- HiOut  out  32  HI register.
- LoOut  out  32  LO register.
- DivZero  out  1  one-cycle pulse: divide with zero divisor completed.

## Operation
- States: IDLE, RUN, FIX.
- IDLE: if MDStart=1 and MDFunct is one of the four codes, latch op type, signedness, |SrcAE|, |SrcBE| (magnitudes only for mult/div; raw for multu/divu), result signs (product/quotient sign = signA XOR signB; remainder sign = signA); clear 64-bit accumulator; count <= 0; go RUN. Unrecognised funct with MDStart=1: ignored, stay IDLE.
- RUN: one iteration per cycle. Multiply: if multiplier LSB set, add multiplicand to upper 33 bits of accumulator, then shift right one. Divide: shift remainder:quotient left one, trial-subtract divisor from remainder (33-bit), keep result and set quotient bit if non-negative. count increments; after iteration ITER-1 go FIX.
- FIX: apply sign correction (two's-complement negate 64-bit product, or quotient and remainder separately), write HI/LO, go IDLE.
- Results: mult/multu HI = product[63:32], LO = product[31:0]. div/divu LO = quotient, HI = remainder.
- Divide by zero: sequence runs full length; at FIX write HI = SrcAE as latched, LO = 32'hFFFFFFFF; DivZero=1 for that one cycle. Signed -2^31 / -1: LO = 32'h80000000, HI = 0 (natural truncation).
- MDBusy = (state != IDLE).
- MDStall = MDBusy & (MDStart | MfRead), combinational. The issuing instruction itself never stalls.
- A stalled MDStart is held by the pipeline and accepted on the first IDLE cycle.
- HiOut/LoOut are registered; mfhi/mflo in EX during IDLE read them directly.

## Timing
- Reset (async, any state): state IDLE, count 0, HI = LO = 0, MDStall = MDBusy = DivZero = 0; any in-flight result is discarded.
- Accept edge T0 -> RUN edges T1..T32 -> FIX edge T33 writes HI/LO, returns IDLE.
- New HI/LO are visible from the cycle after T33, i.e. 33 cycles after acceptance. MDBusy is high for exactly 33 cycles.
- Dependent mf*/mult/div entering EX the cycle after T0 sees MDStall high for 33 cycles. It proceeds in the first IDLE cycle and reads the new value.
- A new start in the same cycle that FIX completes is not possible: state is not IDLE during FIX, so that start stalls one cycle.
- MDStall has no register stage: it is asserted in the same cycle the condition arises.

## Test plan
- mult SrcA=7, SrcB=-3 (32'hFFFFFFFD) -> after 33 cycles HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; MDBusy high 33 cycles.
- multu 32'hFFFFFFFF × 32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
- div -7/2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. divu 100/7 -> LO=14, HI=2.
- divu 32'h1234 / 0 -> HI=32'h00001234, LO=32'hFFFFFFFF, DivZero pulses exactly one cycle at T33.
- mult then mfhi entering EX next cycle -> MDStall high 33 cycles, then mfhi reads the new HI. An add between them is not stalled.
- rst_n low at RUN count 10 -> immediately IDLE, HI=LO=0, MDStall=0. A fresh mult after release completes normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS mult/multu/div/divu sequencer with HI/LO result registers.
// Shift-add multiply and restoring divide share one 64-bit accumulator.
//
// state | meaning
// IDLE  | waiting for a recognised mult/div; HI/LO stable and readable
// RUN   | one multiply/divide iteration per cycle, ITER iterations
// FIX   | sign correction, HI/LO write, divide-by-zero flag
module muldiv_sequencer #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MDStart,
  input  logic [5:0]  MDFunct,
  input  logic        MfRead,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic        MDStall,
  output logic        MDBusy,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        DivZero
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [63:0]   acc;
  logic [31:0]   op;
  logic [31:0]   raw_a;
  logic          is_div, neg_q, neg_r, div_zero;

  logic        valid_op, start, op_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] mul_next, div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Funct codes 0110xx: bit1 selects divide, bit0 selects unsigned.
  assign valid_op  = MDStart & (MDFunct[5:2] == 4'b0110);
  assign start     = (state == IDLE) & valid_op;
  assign op_signed = ~MDFunct[0];
  assign a_neg     = op_signed & SrcAE[31];
  assign b_neg     = op_signed & SrcBE[31];
  assign a_mag     = a_neg ? (~SrcAE + 32'd1) : SrcAE;
  assign b_mag     = b_neg ? (~SrcBE + 32'd1) : SrcBE;

  // Multiply: low half of acc holds the multiplier and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, op} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};

  // Divide: acc = remainder:quotient, quotient bits shift in from the right.
  assign div_shift = acc[63:31];
  assign div_diff  = div_shift - {1'b0, op};
  assign div_next  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                  : {div_diff[31:0],  acc[30:0], 1'b1};

  assign prod_fix = neg_q ? (~acc + 64'd1) : acc;
  assign quo_fix  = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem_fix  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_op) state_nxt = RUN;
      RUN:     if (count == CW'(ITER - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MDBusy  = (state != IDLE);
    MDStall = MDBusy & (MDStart | MfRead);
    DivZero = (state == FIX) & is_div & div_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      acc      <= '0;
      op       <= '0;
      raw_a    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      HiOut    <= '0;
      LoOut    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= MDFunct[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (SrcBE == 32'd0);
            raw_a    <= SrcAE;
            op       <= MDFunct[1] ? b_mag : a_mag;
            acc      <= {32'd0, (MDFunct[1] ? a_mag : b_mag)};
            count    <= '0;
          end
        end
        RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + CW'(1);
        end
        FIX: begin
          if (!is_div) begin
            HiOut <= prod_fix[63:32];
            LoOut <= prod_fix[31:0];
          end else if (div_zero) begin
            HiOut <= raw_a;
            LoOut <= 32'hFFFF_FFFF;
          end else begin
            HiOut <= rem_fix;
            LoOut <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus queues expected HI/LO,
// a monitor compares them when MDBusy falls.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MDStart = 1'b0;
  logic [5:0]  MDFunct = 6'd0;
  logic        MfRead = 1'b0;
  logic [31:0] SrcAE = 32'd0;
  logic [31:0] SrcBE = 32'd0;
  logic        MDStall, MDBusy, DivZero;
  logic [31:0] HiOut, LoOut;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  muldiv_sequencer #(.ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .MDStart(MDStart), .MDFunct(MDFunct),
    .MfRead(MfRead), .SrcAE(SrcAE), .SrcBE(SrcBE), .MDStall(MDStall),
    .MDBusy(MDBusy), .HiOut(HiOut), .LoOut(LoOut), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Holds MDStart through any stall; the expectation is queued at the accept edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                       input bit push);
    int n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    MDStart = 1'b1; MDFunct = f; SrcAE = a; SrcBE = b;
    @(negedge clk);
    while (MDStall && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (MDStall) begin
      total++;
      $display("FAIL issue_timeout: stall still %b after %0d cycles", MDStall, n);
    end
    @(posedge clk);
    if (push) begin
      e.hi = hi; e.lo = lo; e.dz = dz;
      sb.push_back(e);
    end
    #1 MDStart = 1'b0;
  endtask

  initial begin : monitor
    bit   prev_busy;
    int   busy_len, dz_cnt;
    exp_t e;
    prev_busy = 0; busy_len = 0; dz_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 0; busy_len = 0; dz_cnt = 0;
      end else begin
        if (DivZero) dz_cnt++;
        if (MDBusy) busy_len++;
        if (prev_busy && !MDBusy) begin
          if (sb.size() == 0) begin
            total++;
            $display("FAIL completion: got an unexpected completion, expected none queued");
          end else begin
            e = sb.pop_front();
            check("hi", HiOut, e.hi);
            check("lo", LoOut, e.lo);
            check("divzero_cycles", 32'(dz_cnt), 32'(e.dz));
            check("busy_cycles", 32'(busy_len), 32'd33);
          end
          busy_len = 0; dz_cnt = 0;
        end
        prev_busy = MDBusy;
      end
    end
  end

  initial begin : stim
    int n;
    repeat (2) @(negedge clk);
    check("rst_hi", HiOut, 32'd0);
    check("rst_lo", LoOut, 32'd0);
    check("rst_busy", 32'(MDBusy), 32'd0);
    check("rst_stall", 32'(MDStall), 32'd0);
    check("rst_divzero", 32'(DivZero), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // mult followed directly by mfhi: stalls for the whole sequence.
    issue(F_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1);
    MfRead = 1'b1;
    n = 0;
    @(negedge clk);
    while (MDStall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mfhi_stall_cycles", 32'(n), 32'd33);
    check("mfhi_reads_new_hi", HiOut, 32'hFFFF_FFFF);
    @(posedge clk); #1 MfRead = 1'b0;

    // multu, an independent add, then mfhi.
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1);
    @(negedge clk);
    check("add_busy", 32'(MDBusy), 32'd1);
    check("add_not_stalled", 32'(MDStall), 32'd0);
    @(posedge clk); #1 MfRead = 1'b1;
    n = 0;
    @(negedge clk);
    while (MDStall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mfhi_after_add_stall", 32'(n), 32'd32);
    check("mfhi_after_add_hi", HiOut, 32'hFFFF_FFFE);
    @(posedge clk); #1 MfRead = 1'b0;

    // Unrecognised funct is ignored.
    @(posedge clk); #1 MDStart = 1'b1; MDFunct = 6'b100000;
    @(posedge clk); #1 MDStart = 1'b0;
    @(negedge clk);
    check("bad_funct_idle", 32'(MDBusy), 32'd0);

    // Back-to-back divides; each start is held until the sequencer is IDLE.
    issue(F_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1);
    issue(F_DIVU, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 1);
    issue(F_DIVU, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1);
    issue(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 1);
    issue(F_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, 1);

    // Reset in the middle of a sequence discards it.
    issue(F_MULT, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0; MfRead = 1'b1;
    #1;
    check("midrun_rst_busy", 32'(MDBusy), 32'd0);
    check("midrun_rst_stall", 32'(MDStall), 32'd0);
    check("midrun_rst_hi", HiOut, 32'd0);
    check("midrun_rst_lo", LoOut, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1; MfRead = 1'b0;

    issue(F_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0, 32'h0000_001E, 1'b0, 1);

    n = 0;
    while ((sb.size() != 0 || MDBusy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", 32'(sb.size()), 32'd0);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
